// File: rtl/saturated_mac_pipe.sv
// Pipelined signed multiply-accumulate with accumulator and output saturation,
// Q-format output shift with optional round-half-up, valid/ready stream I/O.
module saturated_mac_pipe #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int Q     = 15,
  parameter int ACC_W = 40,
  parameter int ROUND = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] z,
  output logic         ov,
  output logic         ov_sticky,
  input  logic         ov_clr
);

  localparam int PW  = 2 * N;
  localparam int RSH = (Q > 0) ? Q - 1 : 0;
  localparam logic signed [ACC_W:0]   RND_ADD = (ROUND != 0 && Q > 0) ? ((ACC_W+1)'(1) <<< RSH) : '0;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. The whole pipe moves
  // together on en, so a stalled output freezes every stage.
  logic en;
  logic accept;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // S1: operand capture
  logic                s1_valid, s1_first, s1_last;
  logic signed [N-1:0] s1_x, s1_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_x     <= x;
        s1_y     <= y;
      end
    end
  end

  // S2: full-precision product; -2^(N-1) squared still fits in 2N bits
  logic                 s2_valid, s2_first, s2_last;
  logic signed [PW-1:0] s2_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_p     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_p     <= PW'(s1_x) * PW'(s1_y);
    end
  end

  // S3: saturating accumulate with per-frame saturation flag
  logic                    s3_valid, s3_last;
  logic signed [ACC_W-1:0] acc;
  logic                    fs;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W:0]   sum;
  logic                    acc_ovf;
  logic signed [ACC_W-1:0] acc_next;
  logic                    fs_next;

  assign p_ext   = ACC_W'(s2_p);
  assign sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(p_ext);
  assign acc_ovf = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    acc_next = sum[ACC_W-1:0];
    fs_next  = fs | acc_ovf;
    if (s2_first) begin
      acc_next = p_ext;
      fs_next  = 1'b0;
    end else if (acc_ovf) begin
      acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      acc      <= '0;
      fs       <= 1'b0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      if (s2_valid) begin
        acc <= acc_next;
        fs  <= fs_next;
      end
    end
  end

  // Output: round, arithmetic shift at ACC_W+1 bits, clamp to M bits
  logic signed [ACC_W:0] rsum;
  logic signed [ACC_W:0] r;
  logic                  fits;
  logic [M-1:0]          z_next;
  logic                  ov_next;
  logic                  produce;

  assign rsum    = (ACC_W+1)'(acc) + RND_ADD;
  assign r       = rsum >>> Q;
  assign fits    = (&r[ACC_W:M-1]) || !(|r[ACC_W:M-1]);
  assign z_next  = fits ? r[M-1:0] :
                   (r[ACC_W] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}});
  assign ov_next = fs | !fits;
  assign produce = en && s3_valid && s3_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
      ov        <= 1'b0;
    end else if (en) begin
      if (s3_valid && s3_last) begin
        out_valid <= 1'b1;
        z         <= z_next;
        ov        <= ov_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // A set on the same edge as ov_clr takes priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov_sticky <= 1'b0;
    end else if (produce && ov_next) begin
      ov_sticky <= 1'b1;
    end else if (ov_clr) begin
      ov_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_saturated_mac_pipe.sv
// Scoreboard bench for saturated_mac_pipe: two instances (default and
// ACC_W=32/ROUND=0) checked against an arithmetic reference model.
module tb_saturated_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        out_ready = 1'b1;
  logic        ov_clr = 1'b0;

  logic        in_ready0, out_valid0, ov0, st0;
  logic        in_ready1, out_valid1, ov1, st1;
  logic [15:0] z0, z1;

  always #5 clk = ~clk;

  saturated_mac_pipe dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_first(in_first), .in_last(in_last), .x(x), .y(y),
    .out_valid(out_valid0), .out_ready(out_ready), .z(z0), .ov(ov0),
    .ov_sticky(st0), .ov_clr(ov_clr)
  );

  saturated_mac_pipe #(.ACC_W(32), .ROUND(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_first(in_first), .in_last(in_last), .x(x), .y(y),
    .out_valid(out_valid1), .out_ready(out_ready), .z(z1), .ov(ov1),
    .ov_sticky(st1), .ov_clr(ov_clr)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;

  // reference model state, index 0 = dut0, 1 = dut1
  longint macc[2];
  bit     mfs[2];
  bit     msticky[2];
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      macc[d]    = 0;
      mfs[d]     = 1'b0;
      msticky[d] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  function automatic void model_beat(int d, logic [15:0] a, logic [15:0] b, bit f, bit l);
    longint p, s, amax, amin, r;
    int     aw;
    bit     oc;
    aw   = (d == 0) ? 40 : 32;
    p    = longint'($signed(a)) * longint'($signed(b));
    amax = (longint'(1) <<< (aw - 1)) - 1;
    amin = -amax - 1;
    if (f) begin
      macc[d] = p;
      mfs[d]  = 1'b0;
    end else begin
      s = macc[d] + p;
      if (s > amax) begin
        macc[d] = amax;
        mfs[d]  = 1'b1;
      end else if (s < amin) begin
        macc[d] = amin;
        mfs[d]  = 1'b1;
      end else begin
        macc[d] = s;
      end
    end
    if (l) begin
      r  = (macc[d] + ((d == 0) ? longint'(16384) : longint'(0))) >>> 15;
      oc = 1'b0;
      if (r > 32767) begin
        r  = 32767;
        oc = 1'b1;
      end else if (r < -32768) begin
        r  = -32768;
        oc = 1'b1;
      end
      if (d == 0) exp_q0.push_back({mfs[d] | oc, r[15:0]});
      else        exp_q1.push_back({mfs[d] | oc, r[15:0]});
    end
  endfunction

  task automatic mon(int d, logic vld, logic [15:0] zz, logic oo, logic st);
    logic [16:0] e;
    bit          exp_st;
    int          n;
    n = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (!vld) return;
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected_result: got z=0x%0h ov=%0d, expected no result", d, zz, oo);
      return;
    end
    e = (d == 0) ? exp_q0[0] : exp_q1[0];
    chk($sformatf("dut%0d result{ov,z}", d), longint'({oo, zz}), longint'(e));
    exp_st = msticky[d] | e[16];
    chk($sformatf("dut%0d ov_sticky", d), longint'(st), longint'(exp_st));
    if (out_ready) begin
      msticky[d] = exp_st;
      if (d == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon(0, out_valid0, z0, ov0, st0);
      mon(1, out_valid1, z1, ov1, st1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic send_beat(logic [15:0] a, logic [15:0] b, bit f, bit l);
    bit done = 1'b0;
    x        = a;
    y        = b;
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (in_ready0 && in_ready1) begin
        @(posedge clk);
        model_beat(0, a, b, f, l);
        model_beat(1, a, b, f, l);
        done = 1'b1;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready in 1000 cycles, expected acceptance");
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && !out_valid0 && !out_valid1) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", exp_q0.size(), exp_q1.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    ov_clr = 1'b1;
    @(posedge clk);
    #1;
    ov_clr = 1'b0;
    msticky[0] = 1'b0;
    msticky[1] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL global_timeout: got no completion, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid0, 0);
    chk("reset z", z0, 0);
    chk("reset ov", ov0, 0);
    chk("reset ov_sticky", st0, 0);
    chk("reset dut1 out_valid", out_valid1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", in_ready0, 1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // first beat after reset without in_first accumulates onto zero
    send_beat(16'h0100, 16'h0100, 1'b0, 1'b1);
    wait_drain();

    // single-beat latency and value
    send_beat(16'h4000, 16'h4000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("latency out_valid before t+3 (%0d)", i), out_valid0, 0);
    end
    @(negedge clk);
    chk("latency out_valid at t+3", out_valid0, 1);
    chk("single beat z", z0, 16'h2000);
    chk("single beat ov", ov0, 0);
    chk("single beat ov_sticky", st0, 0);
    wait_drain();

    // output saturation, sticky clear, and set-wins-over-clear
    send_beat(16'h8000, 16'h8000, 1'b1, 1'b1);
    wait_drain();
    chk("sticky set dut0", st0, 1);
    chk("sticky set dut1", st1, 1);
    pulse_clr();
    @(negedge clk);
    chk("sticky cleared dut0", st0, 0);
    chk("sticky cleared dut1", st1, 0);
    @(posedge clk);
    #1;
    send_beat(16'h8000, 16'h8000, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    ov_clr = 1'b1;
    @(posedge clk);
    #1;
    ov_clr = 1'b0;
    wait_drain();
    chk("sticky set wins dut0", st0, 1);
    chk("sticky set wins dut1", st1, 1);
    pulse_clr();

    // four-beat frame followed by an independent single-beat frame
    for (int i = 0; i < 4; i++) send_beat(16'h2000, 16'h4000, i == 0, i == 3);
    send_beat(16'h1234, 16'h0100, 1'b1, 1'b1);
    wait_drain();

    // rounding boundaries
    send_beat(16'h0001, 16'h4000, 1'b1, 1'b1);
    send_beat(16'hFFFF, 16'h4000, 1'b1, 1'b1);
    wait_drain();

    // accumulator saturation (hits dut1's 32-bit accumulator), then a clean frame
    for (int i = 0; i < 8; i++) send_beat(16'h8000, 16'h8000, i == 0, i == 7);
    send_beat(16'h0100, 16'h0100, 1'b1, 1'b1);
    wait_drain();
    pulse_clr();

    // randomized frames with random gaps and backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        logic [15:0] a, c;
        a = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        c = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_beat(a, c, b == 0, b == len - 1);
      end
    end
    rand_ready = 1'b0;
    wait_drain();

    // reset in the middle of a frame discards the partial sum
    send_beat(16'h7000, 16'h7000, 1'b1, 1'b0);
    send_beat(16'h7000, 16'h7000, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("mid-frame reset out_valid", out_valid0, 0);
    chk("mid-frame reset ov_sticky", st0, 0);
    chk("mid-frame reset dut1 ov_sticky", st1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(16'h4000, 16'h4000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("post-reset out_valid", out_valid0, 1);
    chk("post-reset z", z0, 16'h2000);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/saturated_mac_pipe.md
Name: saturated_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate with saturation at both the accumulator and the output.
- Output uses a Q-format shift with selectable rounding.
- Successor to the combinational saturating multiplier. Used in the FPGA control math blocks for FIR taps, PI/PID dot-products and coordinate transforms.
- Uses a valid/ready stream interface with frame delimiting by first/last flags, and provides per-result and sticky overflow reporting.

Parameters:
- N, 16: width of signed inputs x, y.
- M, 16: width of signed output z.
- Q, 15: fractional right shift applied to the accumulator before output; 0 <= Q < ACC_W.
- ACC_W, 40: accumulator width; ACC_W >= 2N and ACC_W - Q >= M.
- ROUND, 1: 1 = round half up (add 2^(Q-1) before shift); 0 = truncate (floor). Ignored when Q = 0.

Ports:
- clk, in, 1: clock; all logic rising-edge.
- rst_n, in, 1: reset, synchronous, active-low.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block can accept a beat.
- in_first, in, 1: beat starts a new accumulation; the accumulator loads the product instead of adding to it.
- in_last, in, 1: beat ends the accumulation; it produces an output result.
- x, in, N: signed operand.
- y, in, N: signed operand.
- out_valid, out, 1: z and ov valid.
- out_ready, in, 1: downstream accepts the result.
- z, out, M: saturated, shifted result.
- ov, out, 1: result saturated somewhere in its frame.
- ov_sticky, out, 1: OR of all ov since reset or ov_clr.
- ov_clr, in, 1: clears ov_sticky.

Behaviour:
- Reset: on a clk edge with rst_n = 0, all outputs and pipeline state go to 0: out_valid, z, ov, ov_sticky, stage valids, accumulator, frame-saturation flag. in_ready reads 1 the cycle after reset.
- Reset mid-frame discards all partial accumulation. The next beat must carry in_first.
- Pipeline advance: en = !out_valid || out_ready. in_ready = en. A beat is accepted when in_valid && in_ready.
- When en = 0, every stage, z, ov and out_valid hold. No beat is lost or duplicated.
- S1 (registered on accept): x, y, first, last, valid.
- S2: P = x*y, full-precision 2N-bit signed product.
- S3, accumulate:
  - If first: acc = sext(P).
  - Else: acc = sat_ACC_W(acc + sext(P)), with the sum computed at ACC_W+1 bits.
  - Clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow.
  - Frame flag fs = (first ? 0 : fs) | acc_overflow_this_beat.
- Output, when the S3 beat has last = 1, at the next enabled edge:
  - r = (acc + (ROUND && Q>0 ? 2^(Q-1) : 0)) >>> Q, computed at ACC_W+1 bits (no wrap).
  - z = r if it fits M signed bits; else 0x7FF..F (r > 0) or 0x800..0 (r < 0).
  - ov = fs | output_clamp.
  - out_valid = 1.
- Latency: a last beat accepted at edge t gives out_valid = 1 after edge t+3, with no stall.
- Throughput: one beat per cycle; back-to-back frames allowed, including single-beat frames where first and last are both 1.
- out_valid clears on the enabled edge where out_ready = 1 unless a new result is produced on that same edge.
- in_first = 0 on the very first beat after reset accumulates onto acc = 0. This is legal and defined.
- ov_sticky:
  - Set on each edge that produces a result with ov = 1.
  - Cleared by ov_clr = 1.
  - If set and clear occur on the same edge, set wins.
- x = y = -2^(N-1) gives P = +2^(2N-2). This is representable in 2N bits, so it causes no product overflow.

Test Plan:
Defaults apply (N=16, M=16, Q=15, ACC_W=40, ROUND=1) unless stated.
1. Single beat first=last=1, x=0x4000, y=0x4000, out_ready=1 -> out_valid at accept+3, z=0x2000, ov=0, ov_sticky=0.
2. x=y=0x8000, single beat -> P=2^30, r=32768 -> z=0x7FFF, ov=1, ov_sticky=1. Then ov_clr pulse -> ov_sticky=0. ov_clr on the same edge as another overflowing result -> ov_sticky stays 1.
3. Four-beat frame, each x=0x2000, y=0x4000, first on beat 0, last on beat 3 -> exactly one result, z=0x4000, ov=0. An immediately following single-beat frame gives its own independent result.
4. Rounding with x=1, y=0x4000:
   - ROUND=1 -> z=1; ROUND=0 -> z=0.
   - x=-1, y=0x4000: ROUND=1 -> z=0; ROUND=0 -> z=0xFFFF.
5. Accumulator saturation, ACC_W=32, Q=15, M=16: eight beats of x=y=0x8000 -> acc clamps at 2^31-1, z=0x7FFF, ov=1. The next frame with first=1 and small operands -> ov=0.
6. Stress with random in_valid and out_ready: results match a reference model in order; z/ov stable while out_valid && !out_ready. Additionally, rst_n=0 for one cycle after two beats of a frame -> out_valid=0, ov_sticky=0, and the next first/last beat x=0x4000, y=0x4000 gives z=0x2000.
